// File: rtl/cpu_pkg.sv
// Shared definitions for the ji3 CPU core: op codes, branch kinds, sequencer phases
// and the per-op write-enable classification used by the sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_CMP = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NEG = 4'd6,
    OP_NOT = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10,
    OP_MOV = 4'd11,
    OP_LD  = 4'd12,
    OP_ST  = 4'd13,
    OP_LIL = 4'd14,
    OP_HLT = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BCC  = 2'b01,
    BR_B    = 2'b10
  } br_e;

  typedef enum logic [2:0] {
    ST_F = 3'd0,
    ST_R = 3'd1,
    ST_X = 3'd2,
    ST_M = 3'd3,
    ST_W = 3'd4,
    ST_H = 3'd5
  } state_e;

  function automatic logic op_writes_flags(input op_e o);
    case (o)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR,
      OP_NEG, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Anything not explicitly excluded writes the register file, like MOV.
  function automatic logic op_writes_rf(input op_e o);
    case (o)
      OP_CMP, OP_ST, OP_HLT: return 1'b0;
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags expiry when the wait
// reaches MEM_TIMEOUT with the access still outstanding.
module mem_wait_timer #(
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_expire
);

  logic [TMO_W-1:0] r_tmo;
  logic             w_waiting;

  assign w_waiting = i_active & ~i_ready;
  assign o_expire  = w_waiting & (r_tmo == TMO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_waiting && !o_expire) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle F/R/X/M/W sequencer for the ji3 core: drives IR/PC/RF/flags and
// memory strobes, resolves branches, halts on HLT or memory timeout.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic             use_im,
  input  logic [1:0]       br,
  input  logic             cond,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             flags_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  logic             r_taken;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;

  op_e  w_op;
  logic w_is_br;
  logic w_mem_phase;
  logic w_expire;
  logic w_unused;

  assign w_op        = op_e'(op);
  assign w_is_br     = (br != BR_NONE);
  assign w_mem_phase = (r_state == ST_F) || (r_state == ST_M);
  assign w_unused    = use_im;

  mem_wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_mem_phase),
    .i_ready  (mem_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_F;
      r_taken   <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_F: begin
          if (w_expire) begin
            r_state <= ST_H;
            r_fault <= 1'b1;
          end else if (mem_ready) begin
            r_state <= ST_R;
          end
        end
        ST_R: r_state <= ST_X;
        ST_X: begin
          if (w_op == OP_HLT) begin
            r_state <= ST_H;
          end else if (w_is_br) begin
            r_taken <= (br == BR_B) | ((br == BR_BCC) & cond);
            r_state <= ST_W;
          end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
            r_state <= ST_M;
          end else begin
            r_state <= ST_W;
          end
        end
        ST_M: begin
          if (w_expire) begin
            r_state <= ST_H;
            r_fault <= 1'b1;
          end else if (mem_ready) begin
            r_state <= ST_W;
          end
        end
        ST_W: begin
          r_taken   <= 1'b0;
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= ST_F;
        end
        ST_H:    r_state <= ST_H;
        default: r_state <= ST_F;
      endcase
    end
  end

  // Strobes are gated by rst_n so an in-flight access drops the instant reset asserts.
  always_comb begin
    ir_we    = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    flags_we = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_F: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
        end
        ST_X: begin
          if ((w_op != OP_HLT) && !w_is_br) flags_we = op_writes_flags(w_op);
        end
        ST_M: begin
          addr_sel = 1'b1;
          mem_re   = (w_op == OP_LD);
          mem_we   = (w_op == OP_ST);
        end
        ST_W: begin
          pc_we  = 1'b1;
          pc_sel = r_taken;
          rf_we  = !w_is_br && op_writes_rf(w_op);
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign halted  = (r_state == ST_H);
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: the driver queues the expected output vector
// for every cycle it drives; a negedge monitor pops and compares.
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       op;
  logic             use_im;
  logic [1:0]       br;
  logic             cond;
  logic             mem_ready;
  logic [2:0]       state;
  logic             ir_we, mem_re, mem_we, addr_sel, flags_we, rf_we, pc_we, pc_sel;
  logic             halted, fault;
  logic [CNT_W-1:0] retired;

  cpu_seq_ctrl #(
    .CNT_W       (CNT_W),
    .TMO_W       (8),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .use_im    (use_im),
    .br        (br),
    .cond      (cond),
    .mem_ready (mem_ready),
    .state     (state),
    .ir_we     (ir_we),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .flags_we  (flags_we),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Strobe bit positions: {ir,re,we,as,fw,rw,pw,ps,h,f}
  localparam logic [9:0] S_IR = 10'b10_0000_0000;
  localparam logic [9:0] S_RE = 10'b01_0000_0000;
  localparam logic [9:0] S_WE = 10'b00_1000_0000;
  localparam logic [9:0] S_AS = 10'b00_0100_0000;
  localparam logic [9:0] S_FW = 10'b00_0010_0000;
  localparam logic [9:0] S_RW = 10'b00_0001_0000;
  localparam logic [9:0] S_PW = 10'b00_0000_1000;
  localparam logic [9:0] S_PS = 10'b00_0000_0100;
  localparam logic [9:0] S_H  = 10'b00_0000_0010;
  localparam logic [9:0] S_F  = 10'b00_0000_0001;

  typedef logic [CNT_W+12:0] vec_t;

  vec_t             exp_q[$];
  string            name_q[$];
  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] exp_ret;
  vec_t             mon_e, mon_a;
  string            mon_n;

  function automatic vec_t pack(input logic [2:0] st, input logic [9:0] s,
                                input logic [CNT_W-1:0] ret);
    return {st, s, ret};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = pack(state, {ir_we, mem_re, mem_we, addr_sel, flags_we, rf_we,
                           pc_we, pc_sel, halted, fault}, retired);
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL %s: got st=%0d s=%b ret=%0d, expected st=%0d s=%b ret=%0d",
                 mon_n, mon_a[CNT_W+12 -: 3], mon_a[CNT_W+9 -: 10], mon_a[CNT_W-1:0],
                 mon_e[CNT_W+12 -: 3], mon_e[CNT_W+9 -: 10], mon_e[CNT_W-1:0]);
      end
    end
  end

  task automatic cyc(input string n, input logic mr, input logic [2:0] st, input logic [9:0] s);
    mem_ready = mr;
    exp_q.push_back(pack(st, s, exp_ret));
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_ret = '0;
    cyc("reset", 1'b0, ST_F, 10'd0);
    cyc("reset", 1'b1, ST_F, 10'd0);
    rst_n = 1'b1;
  endtask

  // One full instruction; cond is only correct during X to show it is sampled there.
  task automatic instr(input string n, input logic [3:0] o, input logic [1:0] b, input logic c,
                       input logic fw, input logic rw, input logic ps,
                       input int unsigned fwait, input int unsigned mwait);
    logic [9:0] ms;
    op   = o;
    br   = b;
    cond = ~c;
    for (int unsigned i = 0; i < fwait; i++) cyc({n, "_Fwait"}, 1'b0, ST_F, S_RE);
    cyc({n, "_F"}, 1'b1, ST_F, S_IR | S_RE);
    cyc({n, "_R"}, 1'b1, ST_R, 10'd0);
    cond = c;
    cyc({n, "_X"}, 1'b1, ST_X, fw ? S_FW : 10'd0);
    cond = ~c;
    if ((o == OP_LD) || (o == OP_ST)) begin
      ms = (o == OP_LD) ? S_RE : S_WE;
      for (int unsigned i = 0; i < mwait; i++) cyc({n, "_Mwait"}, 1'b0, ST_M, S_AS | ms);
      cyc({n, "_M"}, 1'b1, ST_M, S_AS | ms);
    end
    cyc({n, "_W"}, 1'b0, ST_W, S_PW | (rw ? S_RW : 10'd0) | (ps ? S_PS : 10'd0));
    exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    op        = OP_ADD;
    use_im    = 1'b0;
    br        = BR_NONE;
    cond      = 1'b0;
    mem_ready = 1'b0;
    exp_ret   = '0;
    @(posedge clk);
    #1;
    do_reset();

    //          name    op      br       c     fw    rw    ps  fw mw
    instr("add",  OP_ADD, BR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    instr("ld",   OP_LD,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2);
    instr("cmp",  OP_CMP, BR_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    instr("st",   OP_ST,  BR_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    instr("bcc0", OP_ADD, BR_BCC,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    instr("bcc1", OP_ADD, BR_BCC,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    instr("b",    OP_ADD, BR_B,    1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    instr("add2", OP_ADD, BR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    instr("not",  OP_NOT, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    instr("sra",  OP_SRA, BR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    instr("lil",  OP_LIL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    instr("mov",  OP_MOV, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    op = OP_HLT;
    br = BR_NONE;
    cyc("hlt_F", 1'b1, ST_F, S_IR | S_RE);
    cyc("hlt_R", 1'b1, ST_R, 10'd0);
    cyc("hlt_X", 1'b1, ST_X, 10'd0);
    for (int i = 0; i < 20; i++) cyc("hlt_H", i[0], ST_H, S_H);

    do_reset();
    op = OP_ADD;
    for (int i = 0; i < 256; i++) cyc("tmo_wait", 1'b0, ST_F, S_RE);
    for (int i = 0; i < 5; i++) cyc("tmo_fault", i[0], ST_H, S_H | S_F);

    do_reset();
    instr("add3", OP_ADD, BR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    op = OP_LD;
    cyc("rstM_F", 1'b1, ST_F, S_IR | S_RE);
    cyc("rstM_R", 1'b1, ST_R, 10'd0);
    cyc("rstM_X", 1'b1, ST_X, 10'd0);
    cyc("rstM_M", 1'b0, ST_M, S_AS | S_RE);
    cyc("rstM_M", 1'b0, ST_M, S_AS | S_RE);
    rst_n   = 1'b0;
    exp_ret = '0;
    cyc("rst_midM", 1'b0, ST_F, 10'd0);
    rst_n = 1'b1;
    instr("add4", OP_ADD, BR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    cyc("after", 1'b1, ST_F, S_IR | S_RE);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
